// File: rtl/serial_sink_to_memory_pkg.sv
// Shared definitions for the serial sink: frame geometry, FSM state encoding
// and a saturating counter helper.
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef NUM_NODES
`define NUM_NODES 16
`endif
`ifndef FRAME_W
`define FRAME_W (`PAYLOAD_SIZE + `ADDR_SZ)
`endif

package serial_sink_to_memory_pkg;

    localparam int ADDR_SZ      = `ADDR_SZ;
    localparam int PAYLOAD_SIZE = `PAYLOAD_SIZE;
    localparam int FRAME_W      = `FRAME_W;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DISCARD,
        CHECK,
        PAUSE
    } sink_state_t;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Start-bit detector and LSB-first deserializer for one serial frame; shared
// with the router input ports.
module serial_rx_shifter
    import serial_sink_to_memory_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               serial_in,
    output logic               start,
    output logic               frame_done,
    output logic [FRAME_W-1:0] shreg
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic             active;
    logic [CNT_W-1:0] bit_cnt;

    assign start      = enable && !active && serial_in;
    assign frame_done = active && (bit_cnt == CNT_W'(FRAME_W - 1));

    // Each data bit enters at the MSB so the first bit ends up at bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start) begin
            active  <= 1'b1;
            bit_cnt <= '0;
        end else if (active) begin
            shreg   <= {serial_in, shreg[FRAME_W-1:1]};
            bit_cnt <= frame_done ? '0 : bit_cnt + CNT_W'(1);
            if (frame_done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_sink_to_memory.sv
// Serial link sink: deserializes frames, keeps payloads addressed to this node
// in a small message memory and back-pressures the upstream transmitter.
module serial_sink_to_memory
    import serial_sink_to_memory_pkg::*;
#(
    parameter int ID       = -1,
    parameter int MSG_SIZE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    serial_in,
    output logic                    busy,
    output logic [PAYLOAD_SIZE-1:0] payload,
    output logic                    payload_valid,
    output logic [7:0]              rx_count,
    output logic [7:0]              misroute_count,
    output logic [7:0]              overrun_count,
    output logic                    done,
    input  logic [3:0]              rd_idx,
    output logic [PAYLOAD_SIZE-1:0] rd_data
);

    localparam int PTR_W     = (MSG_SIZE > 1) ? $clog2(MSG_SIZE) : 1;
    localparam int MEM_DEPTH = 2 ** PTR_W;
    localparam logic [ADDR_SZ-1:0] ID_ADDR = ADDR_SZ'(ID);

    sink_state_t               state;
    logic                      rx_start;
    logic                      frame_done;
    logic [FRAME_W-1:0]        shreg;
    logic [PTR_W-1:0]          wr_ptr;
    logic                      hit;
    logic                      addr_match;
    logic [PAYLOAD_SIZE-1:0]   field;
    logic [PAYLOAD_SIZE-1:0]   mem [MEM_DEPTH];

    serial_rx_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .enable     (state == IDLE),
        .serial_in  (serial_in),
        .start      (rx_start),
        .frame_done (frame_done),
        .shreg      (shreg)
    );

    assign addr_match = (shreg[ADDR_SZ-1:0] == ID_ADDR);
    assign field      = shreg[FRAME_W-1:ADDR_SZ];

    // Once done, the pointer parks on the last slot instead of stepping past it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            payload        <= '0;
            payload_valid  <= 1'b0;
            rx_count       <= '0;
            misroute_count <= '0;
            overrun_count  <= '0;
            done           <= 1'b0;
            wr_ptr         <= '0;
            hit            <= 1'b0;
        end else begin
            payload_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_start) begin
                        busy <= 1'b1;
                        if (done) begin
                            overrun_count <= sat_inc(overrun_count);
                            state         <= DISCARD;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (frame_done) state <= CHECK;
                end
                DISCARD: begin
                    if (frame_done) state <= IDLE;
                end
                CHECK: begin
                    hit <= addr_match;
                    if (addr_match) begin
                        payload  <= field;
                        rx_count <= sat_inc(rx_count);
                        if (int'(wr_ptr) == MSG_SIZE - 1) begin
                            done <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end else begin
                        misroute_count <= sat_inc(misroute_count);
                    end
                    state <= PAUSE;
                end
                PAUSE: begin
                    payload_valid <= hit;
                    busy          <= done;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Message memory survives reset; only the write pointer is cleared.
    always_ff @(posedge clk) begin
        if (state == CHECK && addr_match && !done) begin
            mem[wr_ptr] <= field;
        end
    end

    assign rd_data = (int'(rd_idx) < MSG_SIZE) ? mem[PTR_W'(rd_idx)] : '0;

endmodule

// File: doc/serial_sink_to_memory.md
Name: serial_sink_to_memory

Overview:
- Receiving end of the node serial link. It deserializes frames driven onto serial_out by a traffic source/tx pair and checks the address field against its own ID.
- Matching payloads are stored in order into an internal message memory; a counter stops reception after MSG_SIZE payloads.
- It drives busy back to the upstream transmitter for flow control, and sits at a network egress port as the traffic sink/scoreboard endpoint.

Parameters:
- ID, -1, node address of this sink; -1 disables $display logging.
- MSG_SIZE, 3, number of payload words to capture before done (≥1).
- FRAME_W, `PAYLOAD_SIZE+`ADDR_SZ, frame data width; derived, not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- serial_in  in  1  serial line from upstream tx; idles at 0.
- busy  out  1  registered; 1 = upstream must not start a new frame.
- payload  out  `PAYLOAD_SIZE  last accepted payload.
- payload_valid  out  1  one-cycle pulse per accepted payload.
- rx_count  out  8  accepted frames (address match), saturating at 255.
- misroute_count  out  8  frames with address != ID, saturating.
- overrun_count  out  8  start bits seen while done=1, saturating.
- done  out  1  sticky; MSG_SIZE payloads stored.
- rd_idx  in  4  message-memory read index.
- rd_data  out  `PAYLOAD_SIZE  combinational mem[rd_idx]; 0 if rd_idx ≥ MSG_SIZE.

Behaviour:
- Frame format: start bit (1), then FRAME_W data bits, one bit per clock, LSB first. Bits [`ADDR_SZ-1:0] are the destination; the upper `PAYLOAD_SIZE bits are the payload. The line returns to 0 after the last bit. No stop bit is sent.
- Reset (reset=0, async): state IDLE; busy=0; payload=0; payload_valid=0; all counters 0; done=0; write pointer 0. Memory contents are not cleared.
- FSM IDLE: when serial_in=1 is sampled, go to RECV, clear bit_cnt, set busy=1.
  - If done=1 instead, increment overrun_count and go to DISCARD.
- FSM RECV: shift serial_in into shreg[FRAME_W-1] (right shift) each cycle. After FRAME_W bits, go to CHECK.
- FSM DISCARD: count FRAME_W bits without storing, then return to IDLE.
- FSM CHECK (1 cycle):
  - If shreg addr == ID[`ADDR_SZ-1:0]: mem[wr_ptr] <= payload field; payload <= payload field; payload_valid=1 in the next cycle; rx_count++; wr_ptr++. If wr_ptr == MSG_SIZE-1, set done.
  - Otherwise: misroute_count++.
  - In both cases go to PAUSE.
- FSM PAUSE (1 cycle): busy stays 1, then go to IDLE. busy drops to 0 at the IDLE entry unless done=1.
- Latency: payload_valid rises FRAME_W+2 rising edges after the edge that sampled the start bit.
- Busy: registered. It is 1 in RECV/DISCARD/CHECK/PAUSE or when done=1, and 0 in IDLE with done=0.
- Boundaries:
  - A start bit in the cycle busy falls is accepted. The edge out of PAUSE into IDLE does not sample serial_in.
  - wr_ptr never wraps; after done, no memory writes occur.
  - All counters saturate at 255.
  - Reset mid-frame aborts it with no count or write; the next full frame decodes normally.
  - Simultaneous done-set and a start bit in CHECK cannot occur, because serial_in is ignored outside IDLE/RECV/DISCARD.
- Logging (ID != -1): on accept, $display("##,rx,%d,%d", ID, addr); on misroute, $display("sink %d misroute %d", ID, addr).

Decomposition:
- Shared defines header (existing) supplies `ADDR_SZ, `PAYLOAD_SIZE, `NUM_NODES.
- Shared package gains the FSM state encoding (IDLE, RECV, DISCARD, CHECK, PAUSE) and the FRAME_W derivation macro.
- One sub-module: serial_rx_shifter. It owns the start detect, bit counter, shreg and frame_done pulse, and is reusable by the router input ports. The FSM, memory and counters stay in the top.

Test Plan (`ADDR_SZ=4, `PAYLOAD_SIZE=8, FRAME_W=12, ID=5, MSG_SIZE=3):
- Reset held 0 for 3 cycles, then released -> busy=0, rx_count=0, misroute_count=0, done=0, payload_valid=0.
- Frame addr=5, payload=0x41 (start, then 0x415 LSB first) -> payload_valid pulse 14 edges after the start edge; payload=0x41; rd_data[0]=0x41; rx_count=1; busy high for 14 cycles.
- Frame addr=3, payload=0x58 -> no payload_valid; misroute_count=1; rx_count unchanged; mem[0] unchanged.
- Back-to-back frames 0x41, 0x42, 0x43 to addr 5, each started the cycle busy falls -> rd_data[0..2]=41,42,43; done=1 after the third; busy stays 1. A fourth frame gives overrun_count=1, rx_count=3, and no payload_valid.
- Reset asserted after 5 data bits of a frame -> counters 0, state IDLE. A following full frame 0x44 to addr 5 gives rx_count=1 and rd_data[0]=0x44.
- 300 matching frames with MSG_SIZE=255 in a widened build -> rx_count saturates at 255 and done=1.
